// File: rtl/player_input_port.sv
// player_input_port: synchronized, debounced player buttons with first-press capture and a clear-on-read CPU window.
// Debounce FSM states: STABLE | accepted vector, watching for change ; COUNTING | candidate held, timing its stability
module player_input_port #(
    parameter logic [15:0] BASE_ADR        = 16'hC000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] gpins,
    input  logic        rd_en,
    input  logic [15:0] adr,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        playerInputFlag
);
    localparam int unsigned   CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {ST_STABLE, ST_COUNTING} db_state_t;

    logic [31:0]   sync1, sync2;
    logic          unused_pins;
    logic [7:0]    btn [4];
    db_state_t     state [4];
    logic [CW-1:0] count [4];
    logic [7:0]    cand [4];
    logic [7:0]    stable [4];
    logic [7:0]    snap [4];
    logic [3:0]    ev, clr, snap_load, pend_next;
    logic [3:0]    pending;
    logic          first_valid;
    logic [1:0]    first_idx, low_idx;
    logic [15:0]   offset, read_word;
    logic          req_valid;
    logic [2:0]    req_off;

    assign unused_pins     = ^gpins[35:32];
    assign offset          = adr - BASE_ADR;
    assign playerInputFlag = |pending;

    // Pins idle high, so the synchronizer resets to "released".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= gpins[31:0];
            sync2 <= sync1;
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            btn[n] = ~sync2[8*n +: 8];
            ev[n]  = (state[n] == ST_COUNTING) && (btn[n] == cand[n]) && (btn[n] != stable[n])
                     && (count[n] == TC) && ((cand[n] & ~stable[n]) != 8'h00);
            clr[n] = req_valid && (req_off == 3'(n + 1));
        end
        // A read-clear and a new press on the same edge: the press wins and reloads the snapshot.
        pend_next = pending & ~clr;
        snap_load = ev & ~pend_next;
        pend_next = pend_next | ev;
        low_idx   = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (ev[n]) low_idx = 2'(n);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 4; n++) begin
                state[n]  <= ST_STABLE;
                count[n]  <= '0;
                cand[n]   <= '0;
                stable[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                case (state[n])
                    ST_STABLE: begin
                        if (btn[n] != stable[n]) begin
                            cand[n]  <= btn[n];
                            count[n] <= '0;
                            state[n] <= ST_COUNTING;
                        end
                    end
                    ST_COUNTING: begin
                        if (btn[n] != cand[n]) begin
                            cand[n]  <= btn[n];
                            count[n] <= '0;
                        end else if (btn[n] == stable[n]) begin
                            count[n] <= '0;
                            state[n] <= ST_STABLE;
                        end else if (count[n] == TC) begin
                            stable[n] <= cand[n];
                            count[n]  <= '0;
                            state[n]  <= ST_STABLE;
                        end else begin
                            count[n] <= count[n] + 1'b1;
                        end
                    end
                    default: state[n] <= ST_STABLE;
                endcase
            end
        end
    end

    always_comb begin
        case (req_off)
            3'd0:    read_word = {9'd0, first_valid, first_idx, pending};
            3'd1:    read_word = {8'h00, snap[0]};
            3'd2:    read_word = {8'h00, snap[1]};
            3'd3:    read_word = {8'h00, snap[2]};
            3'd4:    read_word = {8'h00, snap[3]};
            3'd5:    read_word = {stable[1], stable[0]};
            3'd6:    read_word = {stable[3], stable[2]};
            default: read_word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            first_valid <= 1'b0;
            first_idx   <= '0;
            req_valid   <= 1'b0;
            req_off     <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            for (int n = 0; n < 4; n++) snap[n] <= '0;
        end else begin
            pending <= pend_next;
            for (int n = 0; n < 4; n++) begin
                if (snap_load[n]) snap[n] <= cand[n];
            end
            if (pend_next == 4'h0) begin
                first_valid <= 1'b0;
                first_idx   <= '0;
            end else if (!first_valid && (ev != 4'h0)) begin
                first_valid <= 1'b1;
                first_idx   <= low_idx;
            end
            req_valid <= rd_en && (offset < 16'd7);
            req_off   <= offset[2:0];
            rd_valid  <= req_valid;
            rd_data   <= req_valid ? read_word : 16'h0000;
        end
    end
endmodule

// File: tb/tb_player_input_port.sv
// Bench for player_input_port: behavioural model checked every cycle plus hand-computed register reads.
module tb_player_input_port;
    localparam int          D    = 4;
    localparam logic [15:0] BASE = 16'hC000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [35:0] gpins = '1;
    logic        rd_en = 1'b0;
    logic [15:0] adr = 16'h0000;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        flag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    player_input_port #(.BASE_ADR(BASE), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .gpins(gpins), .rd_en(rd_en), .adr(adr),
        .rd_data(rd_data), .rd_valid(rd_valid), .playerInputFlag(flag)
    );

    // Model: debounced value = a sync value held for D+1 consecutive samples.
    logic [31:0] m_syn [2];
    logic [7:0]  m_stable [4];
    logic [7:0]  m_snap [4];
    logic [7:0]  m_run_val [4];
    int          m_run_len [4];
    logic [3:0]  m_pending;
    logic        m_fv;
    logic [1:0]  m_fi;
    logic        m_req_v;
    int          m_req_off;
    logic [15:0] m_rd_data;
    logic        m_rd_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_syn[0] = '1;
        m_syn[1] = '1;
        for (int n = 0; n < 4; n++) begin
            m_stable[n] = 8'h00; m_snap[n] = 8'h00; m_run_val[n] = 8'h00; m_run_len[n] = 0;
        end
        m_pending = 4'h0; m_fv = 1'b0; m_fi = 2'd0;
        m_req_v = 1'b0; m_req_off = 0; m_rd_data = 16'h0; m_rd_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] seen;
        logic [3:0]  clr, ev, pend;
        logic [15:0] off;
        logic [7:0]  b;
        clr = 4'h0;
        ev  = 4'h0;
        m_rd_valid = m_req_v;
        m_rd_data  = 16'h0;
        if (m_req_v) begin
            if (m_req_off == 0) m_rd_data = {9'd0, m_fv, m_fi, m_pending};
            else if (m_req_off <= 4) begin
                m_rd_data = {8'h00, m_snap[m_req_off-1]};
                clr[m_req_off-1] = 1'b1;
            end
            else if (m_req_off == 5) m_rd_data = {m_stable[1], m_stable[0]};
            else m_rd_data = {m_stable[3], m_stable[2]};
        end
        seen = ~m_syn[1];
        m_syn[1] = m_syn[0];
        m_syn[0] = gpins[31:0];
        for (int n = 0; n < 4; n++) begin
            b = seen[8*n +: 8];
            if (b == m_run_val[n]) begin
                if (m_run_len[n] < 1000) m_run_len[n]++;
            end else begin
                m_run_val[n] = b;
                m_run_len[n] = 1;
            end
            if (m_run_len[n] >= D + 1 && m_run_val[n] != m_stable[n]) begin
                if ((m_run_val[n] & ~m_stable[n]) != 8'h00) ev[n] = 1'b1;
                m_stable[n] = m_run_val[n];
            end
        end
        pend = m_pending & ~clr;
        for (int n = 0; n < 4; n++) begin
            if (ev[n] && !pend[n]) begin
                pend[n] = 1'b1;
                m_snap[n] = m_stable[n];
            end
        end
        if (pend == 4'h0) begin
            m_fv = 1'b0; m_fi = 2'd0;
        end else if (!m_fv && ev != 4'h0) begin
            m_fv = 1'b1;
            for (int n = 3; n >= 0; n--) if (ev[n]) m_fi = 2'(n);
        end
        m_pending = pend;
        off = adr - BASE;
        m_req_v = rd_en && (off < 16'd7);
        m_req_off = int'(off);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_valid});
            chk("cyc_rd_data", {16'd0, rd_data}, {16'd0, m_rd_data});
            chk("cyc_flag", {31'd0, flag}, {31'd0, |m_pending});
        end
    end

    task automatic do_read(input logic [15:0] a, output logic [15:0] data, output logic valid);
        rd_en = 1'b1;
        adr   = a;
        @(negedge clk);
        rd_en = 1'b0;
        adr   = 16'($urandom);
        @(negedge clk);
        data  = rd_data;
        valid = rd_valid;
    endtask

    logic [15:0] d;
    logic        v;
    int          hold [4];

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_flag", {31'd0, flag}, 32'd0);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // single press
        gpins[7:0] = 8'hFE;
        repeat (6) @(negedge clk);
        chk("press_flag_edge5", {31'd0, flag}, 32'd0);
        @(negedge clk);
        chk("press_flag_edge6", {31'd0, flag}, 32'd1);
        do_read(16'hC000, d, v);
        chk("press_status", {16'd0, d}, 32'h0041);
        chk("press_status_valid", {31'd0, v}, 32'd1);
        do_read(16'hC001, d, v);
        chk("press_player0", {16'd0, d}, 32'h0001);
        chk("press_flag_cleared", {31'd0, flag}, 32'd0);
        gpins[7:0] = 8'hFF;
        repeat (10) @(negedge clk);

        // bounce on player 1
        for (int i = 0; i < 10; i++) begin
            gpins[8] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("bounce_no_event", {31'd0, flag}, 32'd0);
            end
        end
        gpins[8] = 1'b0;
        repeat (6) @(negedge clk);
        chk("bounce_flag_edge5", {31'd0, flag}, 32'd0);
        @(negedge clk);
        chk("bounce_flag_edge6", {31'd0, flag}, 32'd1);
        do_read(16'hC002, d, v);
        chk("bounce_snap1", {16'd0, d}, 32'h0001);
        gpins[8] = 1'b1;
        repeat (10) @(negedge clk);

        // simultaneous press of players 2 and 3
        gpins[16] = 1'b0;
        gpins[24] = 1'b0;
        repeat (8) @(negedge clk);
        do_read(16'hC000, d, v);
        chk("simul_status", {16'd0, d}, 32'h006C);
        do_read(16'hC003, d, v);
        chk("simul_p2", {16'd0, d}, 32'h0001);
        do_read(16'hC004, d, v);
        chk("simul_p3", {16'd0, d}, 32'h0001);
        do_read(16'hC000, d, v);
        chk("simul_status_clear", {16'd0, d}, 32'h0000);
        gpins[31:0] = '1;
        repeat (10) @(negedge clk);

        // first snapshot held
        gpins[7:0] = 8'hFE;
        repeat (8) @(negedge clk);
        gpins[7:0] = 8'hFC;
        repeat (8) @(negedge clk);
        do_read(16'hC001, d, v);
        chk("held_snap0", {16'd0, d}, 32'h0001);
        do_read(16'hC005, d, v);
        chk("held_live01", {16'd0, d}, 32'h0003);
        do_read(16'hC006, d, v);
        chk("held_live23", {16'd0, d}, 32'h0000);

        // collision of a PLAYER0 read with a new player 0 press
        gpins[7:0] = 8'hF8;
        repeat (8) @(negedge clk);
        gpins[7:0] = 8'hF0;
        repeat (5) @(negedge clk);
        do_read(16'hC001, d, v);
        chk("coll_old_snap", {16'd0, d}, 32'h0007);
        chk("coll_pending_kept", {31'd0, flag}, 32'd1);
        do_read(16'hC001, d, v);
        chk("coll_new_snap", {16'd0, d}, 32'h000F);
        chk("coll_flag_cleared", {31'd0, flag}, 32'd0);

        // out-of-window reads
        do_read(16'hC007, d, v);
        chk("oow_c007_valid", {31'd0, v}, 32'd0);
        chk("oow_c007_data", {16'd0, d}, 32'd0);
        do_read(16'hBFFF, d, v);
        chk("oow_bfff_valid", {31'd0, v}, 32'd0);

        // reset with pending = 0101, mid-read
        gpins[7:0] = 8'hFF;
        repeat (10) @(negedge clk);
        gpins[0]  = 1'b0;
        gpins[16] = 1'b0;
        repeat (8) @(negedge clk);
        do_read(16'hC000, d, v);
        chk("rst_pre_status", {16'd0, d}, 32'h0045);
        rd_en = 1'b1;
        adr   = 16'hC001;
        @(negedge clk);
        #2 rst = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("rst_async_flag", {31'd0, flag}, 32'd0);
        chk("rst_async_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_async_data", {16'd0, rd_data}, 32'd0);
        gpins = '1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_read(16'hC000, d, v);
        chk("rst_post_status", {16'd0, d}, 32'h0000);
        chk("rst_post_valid", {31'd0, v}, 32'd1);

        // randomized traffic against the model
        for (int n = 0; n < 4; n++) hold[n] = 0;
        repeat (3000) begin
            for (int n = 0; n < 4; n++) begin
                if (hold[n] == 0) begin
                    gpins[8*n +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                    hold[n] = $urandom_range(1, 10);
                end
                hold[n]--;
            end
            gpins[35:32] = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rd_en = 1'b1;
                adr   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 8));
            end else begin
                rd_en = 1'b0;
                adr   = 16'($urandom);
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/player_input_port.md
# player_input_port

Memory-mapped responder that serves controller button state from the `gpio1` header to the processor's load path. It synchronizes and debounces four 8-button player inputs and latches each player's first press. It also records which player pressed first and answers CPU reads in the I/O window, with clear-on-read semantics. It sits between the GPIO pins and the exmem read mux, and drives the `playerInputFlag` seen by the memory stage.

## Interface
- `BASE_ADR`, 16'hC000, first address of the I/O window (7 words).
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a new button vector; minimum 2.

Ports:
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: reset, asynchronous assert, active-low; synchronous release is the integrator's job.
- `gpins` input 36: raw header pins. Player n (0..3) buttons are on `gpins[8n+7:8n]` and are active-low (0 = pressed). `gpins[35:32]` are unused.
- `rd_en` input 1: one-cycle CPU read strobe.
- `adr` input 16: read address, sampled when `rd_en`=1.
- `rd_data` output 16: registered read data.
- `rd_valid` output 1: one-cycle pulse qualifying `rd_data`.
- `playerInputFlag` output 1: OR of all per-player pending bits.

## Operation
- **Synchronizer.** `gpins[31:0]` pass through 2 flops and are inverted after them, so internal 1 = pressed. The flops reset to all-1 at the pins, which means released.
- **Debounce.** There is one FSM per player, operating on the whole 8-bit vector.
  - States are STABLE and COUNTING.
  - STABLE: if the sync vector differs from `stable[n]`, latch it as `cand[n]`, set count to 0, and go to COUNTING.
  - COUNTING: if the sync vector differs from `cand[n]`, reload `cand[n]` and restart count at 0.
  - COUNTING: if the sync vector equals `stable[n]`, return to STABLE.
  - COUNTING: otherwise increment the count. When count = `DEBOUNCE_CYCLES`-1, set `stable[n]` to `cand[n]` and go to STABLE.
  - The counter width is `$clog2(DEBOUNCE_CYCLES)`. It never wraps.
- **Press event.** A press event for player n occurs when a `stable[n]` update sets any bit that was previously 0. Releases are not events.
  - On an event with `pending[n]`=0: `snap[n]` takes the new stable vector and `pending[n]` is set to 1.
  - On an event with `pending[n]`=1: nothing changes. The first snapshot is kept.
- **First-player arbitration.**
  - If `first_valid`=0 when one or more events occur, set `first_valid`=1 and set `first_idx` to the lowest-index player with an event that cycle.
  - `first_valid` clears on the edge where the next value of `pending` is all zero.
- **Register map.** Offsets are relative to `BASE_ADR`.
  - +0 STATUS: [3:0] pending, [5:4] `first_idx`, [6] `first_valid`, other bits 0. No side effect.
  - +1..+4 PLAYERn (n = offset-1): [7:0] `snap[n]`, other bits 0. The read clears `pending[n]`.
  - +5 LIVE01: {`stable[1]`, `stable[0]`}. No side effect.
  - +6 LIVE23: {`stable[3]`, `stable[2]`}. No side effect.
- **Reads outside the window.** If `rd_en`=1 with `adr` outside `BASE_ADR`..`BASE_ADR`+6, `rd_valid` stays 0, `rd_data` is 0, and there is no side effect.
- **Read/event collision.** If a PLAYERn read and an event for player n occur on the same cycle, the set wins.
  - `rd_data` returns the old `snap[n]`.
  - `snap[n]` reloads with the new vector.
  - `pending[n]` stays 1.
- **Back-to-back reads.** `rd_en` may be asserted every cycle, and each read is independent.

## Timing
- **Reset values** (asynchronous, while `rst`=0):
  - `rd_data`=0, `rd_valid`=0, `playerInputFlag`=0.
  - `stable`, `cand`, `snap` and `pending` are all 0.
  - `first_valid`=0, `first_idx`=0.
  - All FSMs are in STABLE with count 0.
  - Asserting reset mid-debounce or mid-read discards that operation.
- **Read latency.** `rd_en` sampled at edge k produces `rd_data` and `rd_valid` valid after edge k+1. The pulse lasts exactly one cycle. The clear takes effect at edge k+1.
- **Pin-to-stable latency.**
  - A pin change sampled at edge 0 reaches the sync output at edge 2.
  - `stable` updates at edge 2+`DEBOUNCE_CYCLES`.
  - `pending` and `playerInputFlag` update on the same edge as `stable`.
- **Glitch rejection.** A glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronization never changes `stable`.

## Test plan
- **Single press** (`DEBOUNCE_CYCLES`=4, `BASE_ADR`=16'hC000): drive `gpins[7:0]`=8'hFE from edge 0 → `stable[0]`=8'h01 and `playerInputFlag`=1 after edge 6. A read at C000 returns 16'h0041. A read at C001 returns 16'h0001, then the flag drops.
- **Bounce:** toggle `gpins[8]` every 2 cycles for 20 cycles, then hold it low → no event during the toggling. The event occurs exactly 6 edges after the final transition, and `snap[1]`=8'h01.
- **Simultaneous press:** players 2 and 3 press on the same edge → STATUS reads 16'h006C (pending=4'b1100, `first_idx`=2, `first_valid`=1). After reading C003 and C004, STATUS reads 16'h0000.
- **First snapshot held:** player 0 presses 8'h01, then adds bit 1 to give stable 8'h03 → C001 returns 16'h0001.
- **Collision:** a C001 read lands on the same edge as a new player 0 event → `rd_data` is the old snapshot, `pending[0]` stays 1, and a second C001 read returns the new vector.
- **Out-of-window read and reset:** `rd_en` with `adr`=16'hC007 → `rd_valid` stays 0. Assert `rst`=0 while pending=4'b0101 → all outputs 0 immediately, and STATUS reads 0 after release.
